// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised writes, sequenced clear.
// Latency: reads 0 cycles (optional write bypass), writes commit on the rising edge, clear takes DEPTH cycles.
// Backpressure: none; busy is high while clearing, and writes and clr_req are dropped then.
module reg_file_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd
);

    localparam int DEPTH = 1 << AW;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic          idle;
    logic          w0;
    logic          w1;

    assign idle = (state == IDLE);
    assign busy = (state == CLEAR);

    // Qualified write strobes: port 0 yields to port 1 on an address collision.
    always_comb begin
        w1 = idle && we1 && !((ZERO_R0 != 0) && (wa1 == '0));
        w0 = idle && we0 && !((ZERO_R0 != 0) && (wa0 == '0)) && !(w1 && (wa1 == wa0));
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == {AW{1'b1}}) begin
                state <= IDLE;
            end
        end else if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
        end
    end

    // Storage has no reset of its own; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt] <= '0;
        end else begin
            if (w0) begin
                mem[wa0] <= wd0;
            end
            if (w1) begin
                mem[wa1] <= wd1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        assign a = ra[k*AW +: AW];

        always_comb begin
            d = mem[a];
            if (!idle) begin
                d = '0;
            end else if ((ZERO_R0 != 0) && (a == '0)) begin
                d = '0;
            end else if ((BYPASS != 0) && w1 && (wa1 == a)) begin
                d = wd1;
            end else if ((BYPASS != 0) && w0 && (wa0 == a)) begin
                d = wd0;
            end
        end

        assign rd[k*DW +: DW] = d;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp with default parameters (DW=32, AW=5, NRD=2, ZERO_R0=1, BYPASS=1).
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rstd;
    logic              clr_req;
    logic              busy;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;

    typedef struct {
        string             name;
        logic              busy;
        logic [NRD*DW-1:0] rd;
    } exp_t;

    exp_t sbq[$];
    exp_t got;
    logic mon_vld = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    reg_file_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk     (clk),
        .rstd    (rstd),
        .clr_req (clr_req),
        .busy    (busy),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .ra      (ra),
        .rd      (rd)
    );

    always #5 clk = ~clk;

    // Monitor: compares every presented read against the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_vld) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                got = sbq.pop_front();
                if (rd !== got.rd || busy !== got.busy) begin
                    errors++;
                    $display("FAIL %s: rd=%h busy=%b, expected rd=%h busy=%b",
                             got.name, rd, busy, got.rd, got.busy);
                end
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic step(input string n,
                        input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] raddr, input logic [DW-1:0] xd, input logic xb,
                        input logic cr);
        exp_t e;
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        ra = {NRD{raddr}};
        clr_req = cr;
        e.name = n;
        e.busy = xb;
        e.rd   = {NRD{xd}};
        sbq.push_back(e);
        mon_vld = 1'b1;
        @(posedge clk);
        #1;
        mon_vld = 1'b0;
        we0 = 1'b0;
        we1 = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [AW-1:0] a, input logic [DW-1:0] xd, input logic xb);
        step(n, 1'b0, '0, '0, 1'b0, '0, '0, a, xd, xb, 1'b0);
    endtask

    // Counts rising edges until busy falls; bounded so a stuck sequencer still reports.
    task automatic wait_idle(input string n, input int exp_edges);
        int cnt_e = 0;
        while (busy !== 1'b0 && cnt_e < 40) begin
            @(posedge clk);
            #1;
            cnt_e++;
        end
        chk(n, cnt_e, exp_edges);
    endtask

    initial begin
        logic [AW-1:0] a;
        rstd = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ra = '0;

        // T1: asynchronous reset mid-cycle, then a full DEPTH-cycle clear
        #12;
        rstd = 1'b0;
        #1;
        chk("t1_busy_async", int'(busy), 1);
        #10;
        rstd = 1'b1;
        wait_idle("t1_clear_edges", 32);
        for (int i = 0; i < 32; i++) begin
            rd_chk($sformatf("t1_read_%0d", i), i[AW-1:0], 32'h0, 1'b0);
        end

        // T2: write then read, including same-cycle bypass
        step("t2_bypass", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        rd_chk("t2_read", 5'd5, 32'hDEADBEEF, 1'b0);
        step("t2_other_addr", 1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 5'd4, 32'h0, 1'b0, 1'b0);
        rd_chk("t2_read3", 5'd3, 32'h11, 1'b0);

        // T3: same-address conflict resolves to port 1; distinct addresses both land
        step("t3_bypass", 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 32'h2, 1'b0, 1'b0);
        rd_chk("t3_read", 5'd7, 32'h2, 1'b0);
        step("t3_dual_byp0", 1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB, 5'd8, 32'hA, 1'b0, 1'b0);
        rd_chk("t3_read8", 5'd8, 32'hA, 1'b0);
        rd_chk("t3_read9", 5'd9, 32'hB, 1'b0);

        // T4: r0 is hardwired to zero, including the bypass path
        step("t4_bypass", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 1'b0);
        rd_chk("t4_read", 5'd0, 32'h0, 1'b0);

        // T5: fill, clear with a concurrent write, writes dropped while busy
        for (int i = 1; i < 32; i++) begin
            step($sformatf("t5_fill_%0d", i), 1'b1, i[AW-1:0], 32'h100 + i,
                 1'b0, '0, '0, i[AW-1:0], 32'h100 + i, 1'b0, 1'b0);
        end
        rd_chk("t5_pre_read2", 5'd2, 32'h102, 1'b0);
        step("t5_clr_edge", 1'b0, '0, '0, 1'b1, 5'd1, 32'h55, 5'd1, 32'h55, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            a = k[AW-1:0] - 1'b1;
            step($sformatf("t5_busy_%0d", k), 1'b1, a, 32'hBAD0 + k,
                 1'b0, '0, '0, a, 32'h0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            rd_chk($sformatf("t5_read_%0d", i), i[AW-1:0], 32'h0, 1'b0);
        end

        // T6: reset at cnt=10 restarts the whole clear
        step("t6_fill20", 1'b1, 5'd20, 32'h20, 1'b0, '0, '0, 5'd20, 32'h20, 1'b0, 1'b0);
        step("t6_clr", 1'b0, '0, '0, 1'b0, '0, '0, 5'd20, 32'h20, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            rd_chk($sformatf("t6_busy_%0d", k), 5'd20, 32'h0, 1'b1);
        end
        #2;
        rstd = 1'b0;
        #1;
        chk("t6_busy_async", int'(busy), 1);
        @(posedge clk);
        #2;
        rstd = 1'b1;
        wait_idle("t6_clear_edges", 32);
        rd_chk("t6_read20", 5'd20, 32'h0, 1'b0);
        rd_chk("t6_read31", 5'd31, 32'h0, 1'b0);

        #20;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
